// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU-side load/store port and its Wishbone master.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS      = 2'd1,
        RESPONSE = 2'd2
    } wishbone_state_t;

    function automatic logic [3:0] size_bytes(input access_size_t s);
        case (s)
            SIZE_BYTE: size_bytes = 4'd1;
            SIZE_HALF: size_bytes = 4'd2;
            SIZE_WORD: size_bytes = 4'd4;
            default:   size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Shifts the returned bus word down to the accessed byte lane, truncates it to
// the access size and sign- or zero-extends it.
module load_aligner
    import cpu_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [OFF_W-1:0]      offset_i,
    input  access_size_t          size_i,
    input  logic                  unsigned_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] top;
    logic [6:0]            nbits;
    logic                  sign;

    // top isolates the MSB of the accessed field so no variable bit index is needed
    always_comb begin
        shifted = data_i >> {offset_i, 3'b000};
        nbits   = {size_bytes(size_i), 3'b000};
        if (32'(nbits) >= DATA_WIDTH) begin
            mask = '1;
        end else begin
            mask = (DATA_WIDTH'(1) << nbits) - DATA_WIDTH'(1);
        end
        top    = mask & ~(mask >> 1);
        sign   = (|(shifted & top)) & ~unsigned_i;
        data_o = (shifted & mask) | (sign ? ~mask : '0);
    end

endmodule

// File: rtl/wishbone_master.sv
// CPU load/store port to Wishbone classic master bridge (IDLE -> BUS -> RESPONSE).
// Optional bus watchdog enabled by defining WISHBONE_TIMEOUT_EN.
module wishbone_master
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned SEL_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     request,
    input  logic                     write_enable,
    input  access_size_t             size,
    input  logic                     unsigned_load,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     ready,
    output logic                     error,
    output logic                     busy,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [ADDRESS_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0]    wb_dat_o,
    output logic [SEL_WIDTH-1:0]     wb_sel_o,
    input  logic [DATA_WIDTH-1:0]    wb_dat_i,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i
);

    localparam int unsigned OFF_W = $clog2(SEL_WIDTH);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $error("wishbone_master: DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("wishbone_master: TIMEOUT_CYCLES must be at least 1");
    end

    wishbone_state_t          state_q, state_d;
    logic                     cyc_q, cyc_d;
    logic                     we_q, we_d;
    logic [SEL_WIDTH-1:0]     sel_q, sel_d;
    logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0]    dat_q, dat_d;
    logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
    logic                     ready_q, ready_d;
    logic                     error_q, error_d;
    logic                     busy_q, busy_d;
    logic [OFF_W-1:0]         offset_q, offset_d;
    access_size_t             size_q, size_d;
    logic                     unsigned_q, unsigned_d;
`ifdef WISHBONE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]         cnt_q, cnt_d;
`endif

    logic [OFF_W-1:0]         req_offset;
    logic [31:0]              req_off32;
    logic                     misaligned_c;
    logic [DATA_WIDTH-1:0]    aligned_c;

    assign req_offset = address[OFF_W-1:0];
    assign req_off32  = 32'(req_offset);

    always_comb begin
        misaligned_c = 1'b0;
        case (size)
            SIZE_HALF:   misaligned_c = req_off32[0];
            SIZE_WORD:   misaligned_c = (req_off32[1:0] != 2'b00);
            SIZE_DOUBLE: misaligned_c = (DATA_WIDTH != 64) || (req_off32 != 32'd0);
            default:     misaligned_c = 1'b0;
        endcase
    end

    load_aligner #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_aligner (
        .data_i     (wb_dat_i),
        .offset_i   (offset_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (aligned_c)
    );

    // Next-state and registered-output logic; ready/error/read_data are pulses by default
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        read_data_d = '0;
        ready_d     = 1'b0;
        error_d     = 1'b0;
        busy_d      = busy_q;
        offset_d    = offset_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
`ifdef WISHBONE_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (request) begin
                    busy_d     = 1'b1;
                    offset_d   = req_offset;
                    size_d     = size;
                    unsigned_d = unsigned_load;
                    if (misaligned_c) begin
                        state_d = RESPONSE;
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                        we_d    = write_enable;
                        adr_d   = {address[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        sel_d   = SEL_WIDTH'((16'd1 << size_bytes(size)) - 16'd1) << req_offset;
                        dat_d   = write_data << {req_offset, 3'b000};
`ifdef WISHBONE_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            BUS: begin
                // err wins over a simultaneous ack
                if (wb_err_i || wb_ack_i) begin
                    state_d = RESPONSE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    error_d = wb_err_i;
                    if (!wb_err_i && !we_q) begin
                        read_data_d = aligned_c;
                    end
                end
`ifdef WISHBONE_TIMEOUT_EN
                else if (32'(cnt_q) == TIMEOUT_CYCLES - 1) begin
                    state_d = RESPONSE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESPONSE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            offset_q    <= '0;
            size_q      <= SIZE_BYTE;
            unsigned_q  <= 1'b0;
`ifdef WISHBONE_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            offset_q    <= offset_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
`ifdef WISHBONE_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign read_data = read_data_q;
    assign ready     = ready_q;
    assign error     = error_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master: vector table plus multi-cycle sequences.
module tb_wishbone_master;
    import cpu_bus_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         request;
    logic         write_enable;
    access_size_t size;
    logic         unsigned_load;
    logic [31:0]  address;
    logic [31:0]  write_data;
    logic [31:0]  read_data;
    logic         ready;
    logic         error;
    logic         busy;
    logic         wb_cyc_o;
    logic         wb_stb_o;
    logic         wb_we_o;
    logic [31:0]  wb_adr_o;
    logic [31:0]  wb_dat_o;
    logic [3:0]   wb_sel_o;
    logic [31:0]  wb_dat_i;
    logic         wb_ack_i;
    logic         wb_err_i;

    int n_vectors   = 0;
    int n_checks    = 0;
    int miscompares = 0;

    wishbone_master #(
        .ADDRESS_WIDTH  (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .request       (request),
        .write_enable  (write_enable),
        .size          (size),
        .unsigned_load (unsigned_load),
        .address       (address),
        .write_data    (write_data),
        .read_data     (read_data),
        .ready         (ready),
        .error         (error),
        .busy          (busy),
        .wb_cyc_o      (wb_cyc_o),
        .wb_stb_o      (wb_stb_o),
        .wb_we_o       (wb_we_o),
        .wb_adr_o      (wb_adr_o),
        .wb_dat_o      (wb_dat_o),
        .wb_sel_o      (wb_sel_o),
        .wb_dat_i      (wb_dat_i),
        .wb_ack_i      (wb_ack_i),
        .wb_err_i      (wb_err_i)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         we;
        access_size_t sz;
        logic         uns;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        int           ack_dly;
        logic         use_err;
        logic         use_ack;
        logic [31:0]  sdata;
        logic         exp_bus;
        logic [31:0]  exp_adr;
        logic [3:0]   exp_sel;
        logic [31:0]  exp_dat;
        logic [31:0]  exp_rd;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic we, input access_size_t sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int dly, input logic e, input logic a, input logic [31:0] sdata,
                                input logic xbus, input logic [31:0] xadr, input logic [3:0] xsel,
                                input logic [31:0] xdat, input logic [31:0] xrd, input logic xerr,
                                input int xlat);
        vec_t v;
        v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.ack_dly = dly; v.use_err = e; v.use_ack = a; v.sdata = sdata;
        v.exp_bus = xbus; v.exp_adr = xadr; v.exp_sel = xsel; v.exp_dat = xdat;
        v.exp_rd = xrd; v.exp_err = xerr; v.exp_lat = xlat;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm, input int idx);
        n_checks++;
        miscompares++;
        $display("FAIL %s[%0d]: no ready within cycle budget", nm, idx);
    endtask

    task automatic drive_req(input logic we, input access_size_t sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        request = 1'b1; write_enable = we; size = sz; unsigned_load = uns;
        address = addr; write_data = wdata;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  stb_start;
        bit  seen;
        bit  done;
        stb_start = 0; seen = 0; done = 0;
        @(negedge clock);
        drive_req(v.we, v.sz, v.uns, v.addr, v.wdata);
        for (int n = 1; n <= 20 && !done; n++) begin
            @(negedge clock);
            // inputs scrambled while busy must not disturb the transaction
            address = $urandom; write_data = $urandom;
            write_enable = 1'($urandom); unsigned_load = 1'($urandom);
            size = access_size_t'($urandom_range(0, 3));
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
            if (wb_cyc_o && !seen) begin
                seen = 1; stb_start = n;
                chk("adr", idx, 64'(wb_adr_o), 64'(v.exp_adr));
                chk("sel", idx, 64'(wb_sel_o), 64'(v.exp_sel));
                chk("dat_o", idx, 64'(wb_dat_o), 64'(v.exp_dat));
                chk("we", idx, 64'(wb_we_o), 64'(v.we));
                chk("stb", idx, 64'(wb_stb_o), 64'd1);
            end
            if (wb_cyc_o && (n - stb_start) == v.ack_dly) begin
                wb_ack_i = v.use_ack; wb_err_i = v.use_err; wb_dat_i = v.sdata;
            end
            if (ready) begin
                done = 1;
                chk("latency", idx, 64'(n), 64'(v.exp_lat));
                chk("error", idx, 64'(error), 64'(v.exp_err));
                chk("read_data", idx, 64'(read_data), 64'(v.exp_rd));
                chk("busy_at_ready", idx, 64'(busy), 64'd1);
                chk("cyc_at_ready", idx, 64'(wb_cyc_o), 64'd0);
                request = 1'b0;
            end
        end
        if (!done) bound_fail("ready", idx);
        chk("bus_cycle", idx, 64'(seen), 64'(v.exp_bus));
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        @(negedge clock);
        chk("ready_pulse", idx, 64'(ready), 64'd0);
        chk("busy_after", idx, 64'(busy), 64'd0);
        n_vectors++;
    endtask

    initial begin
        bit bad;
        bit done;
        reset = 1'b1; request = 1'b0; write_enable = 1'b0; size = SIZE_BYTE;
        unsigned_load = 1'b0; address = '0; write_data = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;

        //        we sz           u  addr        wdata        d  e  a  sdata         bus adr         sel   dat_o         rd            err lat
        vecs[0]  = mk(0, SIZE_WORD,   0, 32'h104, 32'h0,        1, 0, 1, 32'hDEADBEEF, 1, 32'h104, 4'hF, 32'h0,        32'hDEADBEEF, 0, 3);
        vecs[1]  = mk(0, SIZE_BYTE,   0, 32'h103, 32'h0,        1, 0, 1, 32'h80000000, 1, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80, 0, 3);
        vecs[2]  = mk(0, SIZE_BYTE,   1, 32'h103, 32'h0,        1, 0, 1, 32'h80000000, 1, 32'h100, 4'h8, 32'h0,        32'h00000080, 0, 3);
        vecs[3]  = mk(1, SIZE_HALF,   0, 32'h102, 32'hABCD,     0, 0, 1, 32'h0,        1, 32'h100, 4'hC, 32'hABCD0000, 32'h0,        0, 2);
        vecs[4]  = mk(0, SIZE_WORD,   0, 32'h101, 32'h0,        0, 0, 1, 32'h0,        0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 1);
        vecs[5]  = mk(0, SIZE_WORD,   0, 32'h200, 32'h0,        0, 1, 1, 32'h12345678, 1, 32'h200, 4'hF, 32'h0,        32'h0,        1, 2);
        vecs[6]  = mk(1, SIZE_BYTE,   0, 32'h001, 32'h5A,       2, 1, 0, 32'h0,        1, 32'h000, 4'h2, 32'h00005A00, 32'h0,        1, 4);
        vecs[7]  = mk(0, SIZE_HALF,   0, 32'h206, 32'h0,        0, 0, 1, 32'h80010000, 1, 32'h204, 4'hC, 32'h0,        32'hFFFF8001, 0, 2);
        vecs[8]  = mk(0, SIZE_HALF,   0, 32'h201, 32'h0,        0, 0, 1, 32'h0,        0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 1);
        vecs[9]  = mk(0, SIZE_DOUBLE, 0, 32'h200, 32'h0,        0, 0, 1, 32'h0,        0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 1);
        vecs[10] = mk(0, SIZE_BYTE,   0, 32'h101, 32'h0,        0, 0, 1, 32'h0000F500, 1, 32'h100, 4'h2, 32'h0,        32'hFFFFFFF5, 0, 2);
        vecs[11] = mk(1, SIZE_WORD,   0, 32'h300, 32'hCAFEF00D, 3, 0, 1, 32'h0,        1, 32'h300, 4'hF, 32'hCAFEF00D, 32'h0,        0, 5);
        vecs[12] = mk(0, SIZE_HALF,   1, 32'h10E, 32'h0,        1, 0, 1, 32'h9ABC1234, 1, 32'h10C, 4'hC, 32'h0,        32'h00009ABC, 0, 3);
        vecs[13] = mk(0, SIZE_HALF,   0, 32'h100, 32'h0,        0, 0, 1, 32'h00007FFF, 1, 32'h100, 4'h3, 32'h0,        32'h00007FFF, 0, 2);

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_cyc", 0, 64'(wb_cyc_o), 64'd0);
        chk("rst_stb", 0, 64'(wb_stb_o), 64'd0);
        chk("rst_we", 0, 64'(wb_we_o), 64'd0);
        chk("rst_sel", 0, 64'(wb_sel_o), 64'd0);
        chk("rst_adr", 0, 64'(wb_adr_o), 64'd0);
        chk("rst_dat", 0, 64'(wb_dat_o), 64'd0);
        chk("rst_rd", 0, 64'(read_data), 64'd0);
        chk("rst_ready", 0, 64'(ready), 64'd0);
        chk("rst_error", 0, 64'(error), 64'd0);
        chk("rst_busy", 0, 64'(busy), 64'd0);
        n_vectors++;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Back-to-back: request held through ready starts a new transaction in the next IDLE cycle
        @(negedge clock);
        drive_req(0, SIZE_WORD, 0, 32'h108, 32'h0);
        @(negedge clock);
        chk("b2b_cyc1", 100, 64'(wb_cyc_o), 64'd1);
        wb_ack_i = 1'b1; wb_dat_i = 32'h11111111;
        @(negedge clock);
        wb_ack_i = 1'b0;
        chk("b2b_ready1", 100, 64'(ready), 64'd1);
        chk("b2b_rd1", 100, 64'(read_data), 64'h11111111);
        @(negedge clock);
        chk("b2b_idle_cyc", 100, 64'(wb_cyc_o), 64'd0);
        chk("b2b_idle_busy", 100, 64'(busy), 64'd0);
        @(negedge clock);
        chk("b2b_cyc2", 100, 64'(wb_cyc_o), 64'd1);
        chk("b2b_busy2", 100, 64'(busy), 64'd1);
        request = 1'b0;
        wb_ack_i = 1'b1; wb_dat_i = 32'h22222222;
        @(negedge clock);
        wb_ack_i = 1'b0;
        chk("b2b_ready2", 100, 64'(ready), 64'd1);
        chk("b2b_rd2", 100, 64'(read_data), 64'h22222222);
        @(negedge clock);
        chk("b2b_ready_drop", 100, 64'(ready), 64'd0);
        n_vectors++;

        // Reset two cycles into BUS abandons the cycle without ready
        @(negedge clock);
        drive_req(0, SIZE_WORD, 0, 32'h104, 32'h0);
        @(negedge clock);
        chk("rstbus_cyc1", 101, 64'(wb_cyc_o), 64'd1);
        @(negedge clock);
        chk("rstbus_cyc2", 101, 64'(wb_cyc_o), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; request = 1'b0;
        chk("rstbus_cyc", 101, 64'(wb_cyc_o), 64'd0);
        chk("rstbus_stb", 101, 64'(wb_stb_o), 64'd0);
        chk("rstbus_busy", 101, 64'(busy), 64'd0);
        chk("rstbus_ready", 101, 64'(ready), 64'd0);
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (ready || wb_cyc_o) bad = 1;
        end
        chk("rstbus_quiet", 101, 64'(bad), 64'd0);
        n_vectors++;

        // Silent slave
        @(negedge clock);
        drive_req(0, SIZE_WORD, 0, 32'h104, 32'h0);
`ifdef WISHBONE_TIMEOUT_EN
        done = 0;
        for (int n = 1; n <= 20 && !done; n++) begin
            @(negedge clock);
            request = 1'b0;
            if (ready) begin
                done = 1;
                chk("timeout_lat", 102, 64'(n), 64'd5);
                chk("timeout_err", 102, 64'(error), 64'd1);
                chk("timeout_cyc", 102, 64'(wb_cyc_o), 64'd0);
            end
        end
        if (!done) bound_fail("timeout", 102);
`else
        done = 0;
        bad = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            request = 1'b0;
            if (!busy || !wb_cyc_o) bad = 1;
            if (ready) done = 1;
        end
        chk("silent_busy_held", 102, 64'(bad), 64'd0);
        chk("silent_no_ready", 102, 64'(done), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("silent_recover", 102, 64'(busy), 64'd0);
`endif
        n_vectors++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, miscompares);
        $finish;
    end

endmodule
